falafel_mem_responder: RTL and testbench

- Memory-side responder for the falafel LSU request/response interface. Accepts one request at a time (load, store, or compare-and-swap on the lock key), executes it against an internal word array, and returns one response after a programmable latency.
- Used as the simulation and FPGA memory behind the LSU. Also provides a backdoor write port so benches can preload free-list headers.

---
 rtl/falafel_mem_responder_if.sv | 26 ++
 rtl/falafel_mem_responder.sv | 138 +++++++++++++
 tb/tb_falafel_mem_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/falafel_mem_responder_if.sv
// Request/response bus between the falafel LSU (master) and its memory responder (slave).
interface falafel_mem_responder_if #(
  parameter int unsigned DATA_W = 64
);
  logic              mem_req_val_i;
  logic              mem_req_rdy_o;
  logic              mem_req_is_write_i;
  logic              mem_req_is_cas_i;
  logic [DATA_W-1:0] mem_req_addr_i;
  logic [DATA_W-1:0] mem_req_data_i;
  logic              mem_rsp_val_o;
  logic              mem_rsp_rdy_i;
  logic [DATA_W-1:0] mem_rsp_data_o;

  modport master (
    output mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
    output mem_req_addr_i, mem_req_data_i, mem_rsp_rdy_i,
    input  mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
  );

  modport slave (
    input  mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
    input  mem_req_addr_i, mem_req_data_i, mem_rsp_rdy_i,
    output mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
  );
endinterface

// File: rtl/falafel_mem_responder.sv
// Memory responder behind the falafel LSU: one load/store/CAS outstanding at a time,
// response after a fixed latency, plus a backdoor write port for preloading.
package falafel_pkg;
  localparam int unsigned       DATA_W    = 64;
  localparam logic [DATA_W-1:0] EMPTY_KEY = '1;
endpackage

module falafel_mem_responder
  import falafel_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_LSB = 3,
  parameter int unsigned LATENCY  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  falafel_mem_responder_if.slave mem,
  input  logic                   init_we_i,
  input  logic [DATA_W-1:0]      init_addr_i,
  input  logic [DATA_W-1:0]      init_data_i,
  output logic                   err_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rdy;
  logic              r_rsp_val;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_req_idx;
  logic [DATA_W-1:0] w_init_idx;
  logic              w_req_inr;
  logic              w_init_inr;
  logic [AW-1:0]     w_req_widx;
  logic [AW-1:0]     w_init_widx;
  logic [DATA_W-1:0] w_rd;
  logic              w_req_rdy;
  logic              w_acc;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rsp;

  assign w_req_idx   = mem.mem_req_addr_i >> ADDR_LSB;
  assign w_init_idx  = init_addr_i >> ADDR_LSB;
  assign w_req_inr   = w_req_idx < DATA_W'(DEPTH);
  assign w_init_inr  = w_init_idx < DATA_W'(DEPTH);
  assign w_req_widx  = w_req_idx[AW-1:0];
  assign w_init_widx = w_init_idx[AW-1:0];
  assign w_rd        = r_mem[w_req_widx];

  // r_rdy is only set in IDLE; gating with rst_ni keeps ready low while reset is held.
  assign w_req_rdy = r_rdy & rst_ni & ~init_we_i;
  assign w_acc     = mem.mem_req_val_i & w_req_rdy;

  always_comb begin
    w_wr_en = 1'b0;
    w_rsp   = '0;
    if (mem.mem_req_is_cas_i) begin
      if (w_req_inr && (w_rd == EMPTY_KEY)) begin
        w_wr_en = 1'b1;
      end else begin
        w_rsp = DATA_W'(1);
      end
    end else if (mem.mem_req_is_write_i) begin
      w_wr_en = w_req_inr;
    end else if (w_req_inr) begin
      w_rsp = w_rd;
    end
  end

  // Array has no reset; backdoor and request writes never coincide since ready drops with init_we_i.
  always_ff @(posedge clk_i) begin
    if (init_we_i && w_init_inr) begin
      r_mem[w_init_widx] <= init_data_i;
    end else if (w_acc && w_wr_en) begin
      r_mem[w_req_widx] <= mem.mem_req_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rdy      <= 1'b1;
      r_rsp_val  <= 1'b0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((w_acc && !w_req_inr) || (init_we_i && !w_init_inr)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_rsp_data <= w_rsp;
            r_rdy      <= 1'b0;
            if (LATENCY == 1) begin
              r_state   <= S_RESP;
              r_rsp_val <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= S_RESP;
            r_rsp_val <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (mem.mem_rsp_rdy_i) begin
            r_state   <= S_IDLE;
            r_rsp_val <= 1'b0;
            r_rdy     <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_rsp_val <= 1'b0;
          r_rdy     <= 1'b1;
        end
      endcase
    end
  end

  assign mem.mem_req_rdy_o  = w_req_rdy;
  assign mem.mem_rsp_val_o  = r_rsp_val;
  assign mem.mem_rsp_data_o = r_rsp_data;
  assign err_o              = r_err;
endmodule

// File: tb/tb_falafel_mem_responder.sv
// Bench for falafel_mem_responder: directed scenarios plus random ops against an array model.
module tb_falafel_mem_responder;
  import falafel_pkg::*;

  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned ADDR_LSB = 3;
  localparam int unsigned LATENCY  = 2;

  logic              clk_i       = 1'b0;
  logic              rst_ni      = 1'b0;
  logic              init_we_i   = 1'b0;
  logic [DATA_W-1:0] init_addr_i = '0;
  logic [DATA_W-1:0] init_data_i = '0;
  logic              err_o;

  falafel_mem_responder_if #(.DATA_W(DATA_W)) bus ();

  falafel_mem_responder #(
    .DEPTH   (DEPTH),
    .ADDR_LSB(ADDR_LSB),
    .LATENCY (LATENCY)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .mem        (bus),
    .init_we_i  (init_we_i),
    .init_addr_i(init_addr_i),
    .init_data_i(init_data_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] model [DEPTH];
  bit                model_err = 1'b0;
  logic [DATA_W-1:0] exp_rsp;
  logic [DATA_W-1:0] a, d;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mk_addr(input longint unsigned idx);
    return (DATA_W'(idx) << ADDR_LSB) | DATA_W'($urandom_range(0, (1 << ADDR_LSB) - 1));
  endfunction

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: one whole operation applied to the array at acceptance time.
  function automatic logic [DATA_W-1:0] model_op(input bit w, input bit cas,
                                                 input logic [DATA_W-1:0] addr,
                                                 input logic [DATA_W-1:0] data);
    longint unsigned idx;
    idx = longint'(addr) / (longint'(1) << ADDR_LSB);
    if ((addr >> ADDR_LSB) >= DATA_W'(DEPTH)) begin
      model_err = 1'b1;
      return cas ? DATA_W'(1) : '0;
    end
    if (cas) begin
      if (model[idx] == EMPTY_KEY) begin
        model[idx] = data;
        return '0;
      end
      return DATA_W'(1);
    end
    if (w) begin
      model[idx] = data;
      return '0;
    end
    return model[idx];
  endfunction

  task automatic backdoor(input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
    init_we_i   = 1'b1;
    init_addr_i = addr;
    init_data_i = data;
    tick();
    init_we_i = 1'b0;
    if ((addr >> ADDR_LSB) < DATA_W'(DEPTH)) model[addr >> ADDR_LSB] = data;
    else model_err = 1'b1;
  endtask

  task automatic issue(input bit w, input bit cas,
                       input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
    int n;
    bus.mem_req_val_i      = 1'b1;
    bus.mem_req_is_write_i = w;
    bus.mem_req_is_cas_i   = cas;
    bus.mem_req_addr_i     = addr;
    bus.mem_req_data_i     = data;
    bus.mem_rsp_rdy_i      = 1'b0;
    #1;
    n = 0;
    while (!bus.mem_req_rdy_o && n < 50) begin
      tick();
      n++;
    end
    chk("req_rdy_before_accept", DATA_W'(bus.mem_req_rdy_o), DATA_W'(1));
    exp_rsp = model_op(w, cas, addr, data);
    tick();
    bus.mem_req_val_i      = 1'b0;
    bus.mem_req_is_write_i = $urandom_range(0, 1) == 1;
    bus.mem_req_is_cas_i   = $urandom_range(0, 1) == 1;
    bus.mem_req_addr_i     = rnd64();
    bus.mem_req_data_i     = rnd64();
  endtask

  task automatic collect(input int hold, input string tag);
    int lat;
    lat = 0;
    while (!bus.mem_rsp_val_o && lat < 50) begin
      chk({tag, "_rdy_wait"}, DATA_W'(bus.mem_req_rdy_o), '0);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, DATA_W'(lat), DATA_W'(LATENCY - 1));
    chk({tag, "_data"}, bus.mem_rsp_data_o, exp_rsp);
    for (int k = 0; k < hold; k++) begin
      bus.mem_req_val_i      = 1'b1;
      bus.mem_req_is_write_i = 1'b1;
      bus.mem_req_is_cas_i   = 1'b0;
      bus.mem_req_addr_i     = mk_addr($urandom_range(0, DEPTH - 1));
      tick();
      chk({tag, "_hold_val"}, DATA_W'(bus.mem_rsp_val_o), DATA_W'(1));
      chk({tag, "_hold_data"}, bus.mem_rsp_data_o, exp_rsp);
      chk({tag, "_hold_rdy"}, DATA_W'(bus.mem_req_rdy_o), '0);
    end
    bus.mem_req_val_i = 1'b0;
    bus.mem_rsp_rdy_i = 1'b1;
    #1;
    chk({tag, "_rdy_before_hs"}, DATA_W'(bus.mem_req_rdy_o), '0);
    tick();
    bus.mem_rsp_rdy_i = 1'b0;
    chk({tag, "_rdy_after_hs"}, DATA_W'(bus.mem_req_rdy_o), DATA_W'(1));
    chk({tag, "_val_after_hs"}, DATA_W'(bus.mem_rsp_val_o), '0);
    chk({tag, "_err"}, DATA_W'(err_o), DATA_W'(model_err));
  endtask

  initial begin
    bus.mem_req_val_i      = 1'b0;
    bus.mem_req_is_write_i = 1'b0;
    bus.mem_req_is_cas_i   = 1'b0;
    bus.mem_req_addr_i     = '0;
    bus.mem_req_data_i     = '0;
    bus.mem_rsp_rdy_i      = 1'b0;

    tick();
    tick();
    chk("rst_rdy", DATA_W'(bus.mem_req_rdy_o), '0);
    chk("rst_val", DATA_W'(bus.mem_rsp_val_o), '0);
    chk("rst_data", bus.mem_rsp_data_o, '0);
    chk("rst_err", DATA_W'(err_o), '0);
    rst_ni = 1'b1;
    #1;
    chk("rel_rdy", DATA_W'(bus.mem_req_rdy_o), DATA_W'(1));

    for (int i = 0; i < DEPTH; i++)
      backdoor(mk_addr(i), ($urandom_range(0, 3) == 0) ? EMPTY_KEY : rnd64());

    backdoor(64'h20, 64'h30);
    issue(1'b0, 1'b0, 64'h20, '0);
    collect(0, "load_preload");

    issue(1'b1, 1'b0, 64'h40, 64'hABCD);
    collect(0, "store");
    issue(1'b0, 1'b0, 64'h40, '0);
    collect(0, "load_after_store");

    backdoor(64'h0, EMPTY_KEY);
    issue(1'b0, 1'b1, 64'h0, 64'h5);
    collect(0, "cas_hit");
    issue(1'b0, 1'b1, 64'h0, 64'h5);
    collect(0, "cas_miss");
    issue(1'b0, 1'b0, 64'h0, '0);
    collect(0, "load_cas_word");

    issue(1'b0, 1'b0, 64'h40, '0);
    collect(5, "hold");

    a = mk_addr(DEPTH - 1);
    issue(1'b1, 1'b0, a, 64'h1234_5678);
    collect(0, "store_last");
    issue(1'b0, 1'b0, a, '0);
    collect(0, "load_last");

    a = DATA_W'(DEPTH) << ADDR_LSB;
    issue(1'b0, 1'b0, a, '0);
    collect(0, "oor_load");
    issue(1'b1, 1'b0, a, 64'h77);
    collect(0, "oor_store");
    issue(1'b0, 1'b1, '1, 64'h77);
    collect(0, "oor_cas");

    a = mk_addr(9);
    d = rnd64();
    bus.mem_req_val_i      = 1'b1;
    bus.mem_req_is_write_i = 1'b0;
    bus.mem_req_is_cas_i   = 1'b0;
    bus.mem_req_addr_i     = a;
    init_we_i   = 1'b1;
    init_addr_i = a;
    init_data_i = d;
    #1;
    chk("init_blocks_rdy", DATA_W'(bus.mem_req_rdy_o), '0);
    tick();
    init_we_i = 1'b0;
    model[a >> ADDR_LSB] = d;
    #1;
    chk("rdy_after_init", DATA_W'(bus.mem_req_rdy_o), DATA_W'(1));
    exp_rsp = model_op(1'b0, 1'b0, a, '0);
    tick();
    bus.mem_req_val_i = 1'b0;
    collect(0, "load_after_init");

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        backdoor(mk_addr($urandom_range(0, 31)),
                 ($urandom_range(0, 1) == 0) ? EMPTY_KEY : rnd64());
      end else begin
        int kind;
        longint unsigned idx;
        kind = $urandom_range(0, 2);
        idx  = ($urandom_range(0, 15) == 0) ? longint'(DEPTH + $urandom_range(0, 100))
                                            : longint'($urandom_range(0, 31));
        issue(kind == 1, kind == 2, mk_addr(idx), rnd64());
        collect($urandom_range(0, 3), "rand");
      end
    end

    a = mk_addr(77);
    d = rnd64();
    issue(1'b1, 1'b0, a, d);
    rst_ni = 1'b0;
    #1;
    chk("midrst_val", DATA_W'(bus.mem_rsp_val_o), '0);
    chk("midrst_rdy", DATA_W'(bus.mem_req_rdy_o), '0);
    tick();
    tick();
    rst_ni    = 1'b1;
    model_err = 1'b0;
    #1;
    chk("postrst_rdy", DATA_W'(bus.mem_req_rdy_o), DATA_W'(1));
    chk("postrst_err", DATA_W'(err_o), '0);
    chk("postrst_data", bus.mem_rsp_data_o, '0);
    issue(1'b0, 1'b0, a, '0);
    collect(0, "load_after_rst");

    backdoor(DATA_W'(DEPTH + 5) << ADDR_LSB, rnd64());
    chk("oor_backdoor_err", DATA_W'(err_o), DATA_W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
